// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, drives the external PC+PC_INC adder,
// issues one outstanding instruction-memory request at a time and hands
// fetched instructions to decode under stall back-pressure. Taken branches
// redirect the PC and squash any fetch already in flight.
module fetch_sequencer #(
    parameter int unsigned          WORD     = 64,
    parameter logic [WORD-1:0]      RESET_PC = '0,
    parameter logic [WORD-1:0]      PC_INC   = WORD'(4)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    output logic [WORD-1:0] adder_a,
    output logic [WORD-1:0] adder_b,
    input  logic [WORD-1:0] adder_sum,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            branch_taken,
    input  logic [WORD-1:0] branch_target,
    input  logic            stall,
    output logic            inst_valid,
    output logic [31:0]     inst_out,
    output logic [WORD-1:0] inst_pc
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [WORD-1:0] pc_q,     pc_d;
    logic            squash_q, squash_d;
    logic            valid_q,  valid_d;
    logic [31:0]     inst_q,   inst_d;
    logic [WORD-1:0] ipc_q,    ipc_d;

    assign adder_a    = pc_q;
    assign adder_b    = PC_INC;
    assign imem_addr  = pc_q;
    assign imem_req   = (state_q == S_REQ);
    assign inst_valid = valid_q;
    assign inst_out   = inst_q;
    assign inst_pc    = ipc_q;

    // Next-state logic; a taken branch overrides every normal transition.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        squash_d = squash_q;
        valid_d  = valid_q;
        inst_d   = inst_q;
        ipc_d    = ipc_q;
        if (branch_taken) begin
            pc_d    = branch_target;
            valid_d = 1'b0;
            case (state_q)
                S_IDLE: state_d = enable ? S_REQ : S_IDLE;
                S_REQ: begin
                    // An accepted old request must still be drained, so mark it squashed.
                    if (imem_ready) begin
                        state_d  = S_WAIT;
                        squash_d = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable) state_d = S_REQ;
                end
                S_REQ: begin
                    if (imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            state_d  = S_REQ;
                        end else begin
                            inst_d  = imem_rdata;
                            ipc_d   = pc_q;
                            valid_d = 1'b1;
                            pc_d    = adder_sum;
                            state_d = S_HOLD;
                        end
                    end
                end
                default: begin
                    if (!stall) begin
                        valid_d = 1'b0;
                        state_d = enable ? S_REQ : S_IDLE;
                    end
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            squash_q <= 1'b0;
            valid_q  <= 1'b0;
            inst_q   <= '0;
            ipc_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            squash_q <= squash_d;
            valid_q  <= valid_d;
            inst_q   <= inst_d;
            ipc_q    <= ipc_d;
        end
    end

endmodule
